comp_ingress_arbiter: RTL and testbench
=======================================

Name: comp_ingress_arbiter

Overview:
Shares one three-way compressor (BPC/ZRL/SR encode plus mode select) between N_CH requesting channels. Each channel submits 512-bit blocks as 8 beats of 64 bits. Arbitration is round-robin and block-atomic. Each granted channel ID is pushed into an in-order tag FIFO, so every compressed 8-beat output block leaving the compressor is labelled with its source channel.

Parameters:
N_CH, 4, number of requesting channels (2..8)
CH_BITWIDTH, $clog2(N_CH), width of the channel ID
D_BITWIDTH, 64, beat width
BEATS_PER_BLK, 8, beats per block (fixed by the compressor)
TAG_DEPTH, 16, tag FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_data_i  in  N_CH*D_BITWIDTH  channel c occupies bits [c*64 +: 64]
req_valid_i  in  N_CH  per-channel beat valid
req_sop_i  in  N_CH  per-channel block start marker
req_eop_i  in  N_CH  per-channel block end marker
req_ready_o  out  N_CH  per-channel beat accept
comp_data_o  out  D_BITWIDTH  beat to compressor
comp_valid_o  out  1  beat valid to compressor
comp_sop_o  out  1  beat 0 marker
comp_eop_o  out  1  beat 7 marker
comp_ready_i  in  1  compressor input ready
comp_out_valid_i  in  1  compressor output beat valid (observed)
comp_out_eop_i  in  1  compressor output last beat (observed)
tag_o  out  CH_BITWIDTH  channel ID of the output block currently streaming
tag_valid_o  out  1  tag FIFO not empty
grant_o  out  CH_BITWIDTH  currently granted channel
busy_o  out  1  in XFER
err_o  out  1  one-cycle protocol error pulse
err_ch_o  out  CH_BITWIDTH  channel of the last error (holds its value)

Behaviour:
- Reset values: all outputs 0; rr_ptr=0, beat_cnt=0, tag FIFO empty, state IDLE. Reset mid-block abandons the block and emits no tag.
- Eligibility (IDLE): channel c is eligible when req_valid_i[c] & req_sop_i[c]. A channel with valid high and sop low is ineligible and stays stalled; no error is raised.
- IDLE: grant is taken only when at least one channel is eligible and tag count < TAG_DEPTH.
  - Winner: first eligible channel scanning rr_ptr, rr_ptr+1, ... mod N_CH.
  - Grant is registered, so XFER starts the next cycle. This gives one bubble cycle between blocks.
- XFER:
  - comp_data_o = req_data_i[grant]; comp_valid_o = req_valid_i[grant].
  - req_ready_o[grant] = comp_ready_i; all other ready bits are 0. In IDLE all ready bits are 0.
  - A beat transfers when comp_valid_o & comp_ready_i; beat_cnt then increments.
  - comp_sop_o = (beat_cnt==0) and comp_eop_o = (beat_cnt==7). Both are generated from beat_cnt, never forwarded from the requester.
  - On the transfer with beat_cnt==7: push grant into the tag FIFO, set rr_ptr = (grant+1) mod N_CH, clear beat_cnt, go to IDLE.
- Requester protocol checks, on transferred beats only:
  - sop at beat_cnt!=0, eop at beat_cnt!=7, or missing eop at beat 7 each raise err_o for 1 cycle and set err_ch_o=grant.
  - The block still completes its 8 beats.
- Tag FIFO:
  - tag_o is the head entry, valid when tag_valid_o is high.
  - Pop on comp_out_valid_i & comp_out_eop_i.
  - Pop while empty: ignored, raises err_o and holds err_ch_o.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full cannot occur, because grant requires count < TAG_DEPTH and each grant pushes once.
- If the compressor stalls (comp_ready_i=0), all XFER outputs hold; beat_cnt is unchanged.

Optional Feature:
COMP_ARB_PRIO_EN:
- Defined: channel 0 has strict priority in IDLE. If eligible it always wins, and rr_ptr is not updated after a channel-0 block. Channels 1..N_CH-1 remain round-robin.
- Undefined: pure round-robin across all channels as described above.

Test Plan:
- Ch2 only sends one block of 8 beats, data 0x2000+i, comp_ready_i=1 → grant_o=2 one cycle after sop; comp_sop_o on beat 0x2000, comp_eop_o on 0x2007; tag_o=2 with tag_valid_o=1; rr_ptr=3.
- All 4 channels hold sop continuously from reset → grant order 0,1,2,3,0; one idle cycle between blocks; tags pop in order 0,1,2,3 on each comp_out eop.
- Ch1 block with comp_ready_i toggling 1,0,1,0 → exactly 8 transfers; beat_cnt frozen during stalls; no duplicated or dropped beats.
- Ch3 asserts eop on beat 5 → err_o pulses once with err_ch_o=3; block still runs 8 beats with comp_eop_o on beat 7.
- Push 16 blocks with no comp_out eop → tag_valid_o=1, no 17th grant, all req_ready_o=0; one output eop pops a tag, after which the next grant occurs.
- With COMP_ARB_PRIO_EN defined, ch0 and ch1 both continuously eligible → ch0 granted every block; ch1 never granted.

Source files
------------

// File: rtl/comp_ingress_arbiter.sv
// Block-atomic round-robin arbiter feeding one shared compressor, with an in-order
// tag FIFO labelling each output block. Define COMP_ARB_PRIO_EN for channel-0 strict priority.
module comp_ingress_arbiter #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CH_BITWIDTH   = $clog2(N_CH),
  parameter int unsigned D_BITWIDTH    = 64,
  parameter int unsigned BEATS_PER_BLK = 8,
  parameter int unsigned TAG_DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH*D_BITWIDTH-1:0]   req_data_i,
  input  logic [N_CH-1:0]              req_valid_i,
  input  logic [N_CH-1:0]              req_sop_i,
  input  logic [N_CH-1:0]              req_eop_i,
  output logic [N_CH-1:0]              req_ready_o,
  output logic [D_BITWIDTH-1:0]        comp_data_o,
  output logic                         comp_valid_o,
  output logic                         comp_sop_o,
  output logic                         comp_eop_o,
  input  logic                         comp_ready_i,
  input  logic                         comp_out_valid_i,
  input  logic                         comp_out_eop_i,
  output logic [CH_BITWIDTH-1:0]       tag_o,
  output logic                         tag_valid_o,
  output logic [CH_BITWIDTH-1:0]       grant_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [CH_BITWIDTH-1:0]       err_ch_o
);

  localparam int unsigned BEAT_BITS = $clog2(BEATS_PER_BLK);
  localparam int unsigned PTR_BITS  = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_BITS  = PTR_BITS + 1;

  localparam logic [BEAT_BITS-1:0]   LAST_BEAT = BEAT_BITS'(BEATS_PER_BLK - 1);
  localparam logic [CH_BITWIDTH-1:0] LAST_CH   = CH_BITWIDTH'(N_CH - 1);
  localparam logic [CH_BITWIDTH:0]   N_CH_W    = (CH_BITWIDTH + 1)'(N_CH);
  localparam logic [CNT_BITS-1:0]    FULL_CNT  = CNT_BITS'(TAG_DEPTH);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state_q, state_d;
  logic [CH_BITWIDTH-1:0] grant_q;
  logic [CH_BITWIDTH-1:0] rr_ptr_q;
  logic [BEAT_BITS-1:0]   beat_cnt_q;

  logic [CH_BITWIDTH-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]    tag_cnt_q;

  logic [N_CH-1:0]        eligible;
  logic [2*N_CH-1:0]      elig_dbl;
  logic [N_CH-1:0]        elig_rot;
  logic                   found;
  logic [CH_BITWIDTH-1:0] rr_off;
  logic [CH_BITWIDTH:0]   rr_sum;
  logic [CH_BITWIDTH-1:0] winner;
  logic                   grant_take;

  logic [D_BITWIDTH-1:0]  sel_data;
  logic                   sel_valid, sel_sop, sel_eop;
  logic                   xfer, beat_fire, last_fire;
  logic                   proto_err, pop_req, pop, pop_err;
  logic                   keep_rr;

  // Rotate the eligibility vector so the scan always starts at rr_ptr, then map back.
  always_comb begin
    eligible = req_valid_i & req_sop_i;
    elig_dbl = {eligible, eligible} >> rr_ptr_q;
    elig_rot = elig_dbl[N_CH-1:0];
    found    = 1'b0;
    rr_off   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found && elig_rot[k]) begin
        found  = 1'b1;
        rr_off = CH_BITWIDTH'(k);
      end
    end
    rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
    winner = (rr_sum >= N_CH_W) ? CH_BITWIDTH'(rr_sum - N_CH_W) : CH_BITWIDTH'(rr_sum);
`ifdef COMP_ARB_PRIO_EN
    if (eligible[0]) begin
      winner = '0;
    end
`endif
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (grant_q == CH_BITWIDTH'(c)) begin
        sel_data  = req_data_i[c*D_BITWIDTH +: D_BITWIDTH];
        sel_valid = req_valid_i[c];
        sel_sop   = req_sop_i[c];
        sel_eop   = req_eop_i[c];
      end
    end
  end

  always_comb begin
    xfer       = (state_q == XFER);
    beat_fire  = xfer && sel_valid && comp_ready_i;
    last_fire  = beat_fire && (beat_cnt_q == LAST_BEAT);
    grant_take = (state_q == IDLE) && (|eligible) && (tag_cnt_q != FULL_CNT);
    proto_err  = beat_fire &&
                 ((sel_sop && (beat_cnt_q != '0)) || (sel_eop != (beat_cnt_q == LAST_BEAT)));
    pop_req    = comp_out_valid_i && comp_out_eop_i;
    pop        = pop_req && (tag_cnt_q != '0);
    pop_err    = pop_req && (tag_cnt_q == '0);
`ifdef COMP_ARB_PRIO_EN
    keep_rr    = (grant_q == '0);
`else
    keep_rr    = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_take) state_d = XFER;
      XFER:    if (last_fire)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    comp_data_o  = xfer ? sel_data : '0;
    comp_valid_o = xfer && sel_valid;
    comp_sop_o   = xfer && (beat_cnt_q == '0);
    comp_eop_o   = xfer && (beat_cnt_q == LAST_BEAT);
    req_ready_o  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      req_ready_o[c] = xfer && (grant_q == CH_BITWIDTH'(c)) && comp_ready_i;
    end
    grant_o     = grant_q;
    busy_o      = xfer;
    tag_valid_o = (tag_cnt_q != '0);
    tag_o       = tag_valid_o ? tag_mem[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_take) begin
        grant_q <= winner;
      end
      if (beat_fire) begin
        beat_cnt_q <= last_fire ? '0 : beat_cnt_q + 1'b1;
      end
      if (last_fire && !keep_rr) begin
        rr_ptr_q <= (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o    <= 1'b0;
      err_ch_o <= '0;
    end else begin
      err_o <= proto_err || pop_err;
      if (proto_err) begin
        err_ch_o <= grant_q;
      end
    end
  end

  // Push/pop both advance their pointers; the count only moves on an unbalanced cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (last_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (last_fire && !pop) begin
        tag_cnt_q <= tag_cnt_q + 1'b1;
      end else if (pop && !last_fire) begin
        tag_cnt_q <= tag_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (last_fire) begin
      tag_mem[wr_ptr_q] <= grant_q;
    end
  end

endmodule

// File: tb/tb_comp_ingress_arbiter.sv
// Scoreboard bench for comp_ingress_arbiter: per-channel block sources, a fake compressor
// output stage, and a queue-based arbitration model predicting beat and tag order.
module tb_comp_ingress_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid, req_sop, req_eop, req_ready;
  logic [DW-1:0]   comp_data;
  logic            comp_valid, comp_sop, comp_eop, comp_ready;
  logic            comp_out_valid, comp_out_eop;
  logic [1:0]      tag, grant, err_ch;
  logic            tag_valid, busy, err;

  always #5 clk = ~clk;

  comp_ingress_arbiter #(.N_CH(N), .D_BITWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_sop_i(req_sop),
    .req_eop_i(req_eop), .req_ready_o(req_ready),
    .comp_data_o(comp_data), .comp_valid_o(comp_valid), .comp_sop_o(comp_sop),
    .comp_eop_o(comp_eop), .comp_ready_i(comp_ready),
    .comp_out_valid_i(comp_out_valid), .comp_out_eop_i(comp_out_eop),
    .tag_o(tag), .tag_valid_o(tag_valid), .grant_o(grant), .busy_o(busy),
    .err_o(err), .err_ch_o(err_ch)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [1:0]  exp_tag_q[$];
  logic [63:0] beat_q[N][$];
  logic [63:0] mdl_q[N][$];
  int          bidx[N];
  int          inj_eop[N];
  int          nvec = 0, nbad = 0;
  int          mdl_rr = 0;
  int          rdy_mode = 0;
  bit          gaps = 0, hold_out = 0, spur_req = 0, spur_now = 0;
  bit          gap_exact = 0, gap_armed = 0;
  int          pend_out = 0, out_beat = 0, in_beats = 0, err_seen = 0;
  longint      cyc = 0, last_eop_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    nvec++;
    if (got !== expv) begin
      nbad++;
      $display("FAIL %s: got %0h required %0h", name, got, expv);
    end
  endtask

  task automatic load(input int c, input int nblk, input bit fixed);
    logic [63:0] d;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 8; i++) begin
        d = fixed ? 64'h2000 + 64'(i) : {$urandom, $urandom};
        beat_q[c].push_back(d);
        mdl_q[c].push_back(d);
      end
    end
  endtask

  // Reference arbitration: every loaded block is eligible at once, so the grant
  // sequence is a plain rotating search over channels that still hold blocks.
  task automatic plan();
    int    pick, c;
    beat_t b;
    forever begin
      pick = -1;
`ifdef COMP_ARB_PRIO_EN
      if (mdl_q[0].size() > 0) pick = 0;
`endif
      for (int k = 0; k < N; k++) begin
        c = (mdl_rr + k) % N;
        if (pick < 0 && mdl_q[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      for (int i = 0; i < 8; i++) begin
        b.ch   = 2'(pick);
        b.data = mdl_q[pick].pop_front();
        b.sop  = (i == 0);
        b.eop  = (i == 7);
        exp_q.push_back(b);
      end
      exp_tag_q.push_back(2'(pick));
`ifdef COMP_ARB_PRIO_EN
      if (pick != 0) mdl_rr = (pick + 1) % N;
`else
      mdl_rr = (pick + 1) % N;
`endif
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend_out > 0 || out_beat > 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (n >= budget) begin
      nbad++;
      $display("FAIL drain_timeout: %0d beats and %0d out-blocks still pending, required 0",
               exp_q.size(), pend_out);
    end
    repeat (3) @(negedge clk);
    chk("tags_drained", {63'd0, tag_valid}, 64'd0);
  endtask

  // Requester sources: present queued beats, advance on accepted beats.
  initial begin
    logic [N-1:0] acc;
    req_valid  = '0;
    req_sop    = '0;
    req_eop    = '0;
    req_data   = '0;
    comp_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      bidx[c]    = 0;
      inj_eop[c] = -1;
    end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (acc[c]) begin
          void'(beat_q[c].pop_front());
          bidx[c] = (bidx[c] + 1) % 8;
          if (bidx[c] == 0) inj_eop[c] = -1;
        end
        if (beat_q[c].size() > 0) begin
          req_data[c*DW +: DW] = beat_q[c][0];
          req_sop[c]   = (bidx[c] == 0);
          req_eop[c]   = (bidx[c] == 7) || (bidx[c] == inj_eop[c]);
          req_valid[c] = (bidx[c] == 0 || !gaps) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end else begin
          req_valid[c] = 1'b0;
          req_sop[c]   = 1'b0;
          req_eop[c]   = 1'b0;
        end
      end
      case (rdy_mode)
        0:       comp_ready = 1'b1;
        1:       comp_ready = ~comp_ready;
        default: comp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Fake compressor output: one 8-beat block per accepted input block.
  initial begin
    comp_out_valid = 1'b0;
    comp_out_eop   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      spur_now = 0;
      if (spur_req) begin
        comp_out_valid = 1'b1;
        comp_out_eop   = 1'b1;
        spur_req = 0;
        spur_now = 1;
      end else if (!hold_out && (out_beat > 0 || pend_out > 0) && $urandom_range(0, 3) != 0) begin
        comp_out_valid = 1'b1;
        comp_out_eop   = (out_beat == 7);
        if (out_beat == 7) begin
          out_beat = 0;
          pend_out--;
        end else begin
          out_beat++;
        end
      end else begin
        comp_out_valid = 1'b0;
        comp_out_eop   = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every transferred beat and every output eop.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (err) err_seen++;
      if (comp_valid && comp_ready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nbad++;
          $display("FAIL unexpected_beat: got ch%0d data %h, required no beat", grant, comp_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant, comp_data, comp_sop, comp_eop} !== {e.ch, e.data, e.sop, e.eop}) begin
            nbad++;
            $display("FAIL beat: got ch%0d data %h sop%0b eop%0b, required ch%0d data %h sop%0b eop%0b",
                     grant, comp_data, comp_sop, comp_eop, e.ch, e.data, e.sop, e.eop);
          end
        end
        if (comp_sop && gap_exact && gap_armed) begin
          nvec++;
          if (cyc - last_eop_cyc != 2) begin
            nbad++;
            $display("FAIL block_gap: got %0d cycles eop-to-sop, required 2", cyc - last_eop_cyc);
          end
        end
        if (comp_eop) begin
          last_eop_cyc = cyc;
          gap_armed    = 1;
        end
        in_beats++;
        if (in_beats == 8) begin
          in_beats = 0;
          pend_out++;
        end
      end
      if (comp_out_valid && comp_out_eop) begin
        nvec++;
        if (spur_now) begin
          if (tag_valid !== 1'b0) begin
            nbad++;
            $display("FAIL empty_tag_valid: got %0b required 0", tag_valid);
          end
        end else if (exp_tag_q.size() == 0) begin
          nbad++;
          $display("FAIL tag_underflow: got tag %0d, required no output block", tag);
        end else if ({tag_valid, tag} !== {1'b1, exp_tag_q[0]}) begin
          nbad++;
          $display("FAIL tag: got valid%0b tag%0d required valid1 tag%0d", tag_valid, tag, exp_tag_q[0]);
          void'(exp_tag_q.pop_front());
        end else begin
          void'(exp_tag_q.pop_front());
        end
      end
    end
  end

  initial begin
    int e0, n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_comp", {59'd0, comp_valid, comp_sop, comp_eop, busy, tag_valid}, 64'd0);
    chk("rst_ids", {54'd0, grant, tag, err_ch, err, req_ready}, 64'd0);
    chk("rst_data", comp_data, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {60'd0, req_ready}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Single ch2 block with counting data.
    #1;
    load(2, 1, 1);
    plan();
    wait_drain(500);

    // All channels loaded together; back-to-back blocks with one bubble each.
    gap_exact = 1;
    gap_armed = 0;
    #1;
    for (int c = 0; c < N; c++) load(c, 2, 0);
    plan();
    wait_drain(2000);
    gap_exact = 0;

    // Compressor ready toggling each cycle.
    rdy_mode = 1;
    #1;
    load(1, 1, 0);
    plan();
    wait_drain(500);
    rdy_mode = 0;

    // Early eop on beat 5 of a ch3 block.
    e0 = err_seen;
    inj_eop[3] = 5;
    #1;
    load(3, 1, 0);
    plan();
    wait_drain(500);
    chk("proto_err_pulses", 64'(err_seen - e0), 64'd1);
    chk("proto_err_ch", {62'd0, err_ch}, 64'd3);

    // Output eop while the tag FIFO is empty.
    e0 = err_seen;
    spur_req = 1;
    repeat (4) @(negedge clk);
    chk("pop_empty_err", 64'(err_seen - e0), 64'd1);
    chk("pop_empty_ch_hold", {62'd0, err_ch}, 64'd3);

    // Fill the tag FIFO: 16 blocks go, the 17th waits for an output eop.
    hold_out = 1;
    #1;
    load(1, 17, 0);
    plan();
    n = 0;
    while (exp_q.size() > 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("full_pending_beats", 64'(exp_q.size()), 64'd8);
    chk("full_tag_valid", {63'd0, tag_valid}, 64'd1);
    chk("full_no_ready", {60'd0, req_ready}, 64'd0);
    chk("full_not_busy", {63'd0, busy}, 64'd0);
    hold_out = 0;
    wait_drain(3000);

    // Randomized rounds: random block counts, valid gaps, random compressor ready.
    e0 = err_seen;
    gaps = 1;
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      #1;
      for (int c = 0; c < N; c++) load(c, $urandom_range(0, 3), 0);
      plan();
      wait_drain(5000);
    end
    chk("random_no_err", 64'(err_seen - e0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
